// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, ALU
// operation requests, opcode/funct constants and ALUControl codes.
// Imported by alu_decoder and mips_multicycle_control.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  // What the FSM asks of the ALU decoder in a given state.
  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_CMP,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: turns the FSM's ALU request plus the instruction
// funct field into the 3-bit ALUControl code.
// Ports: alu_op (request), funct (instr[5:0]) -> alu_control, funct_valid.
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  always_comb begin
    alu_control = ALU_ADD;
    funct_valid = 1'b1;
    case (alu_op)
      ALUOP_CMP: alu_control = ALU_CMP;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alu_control = ALU_ADD;
          F_SUB:   alu_control = ALU_SUB;
          F_AND:   alu_control = ALU_AND;
          F_OR:    alu_control = ALU_OR;
          default: funct_valid = 1'b0; // control stays at ADD, caller flags it
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM (Moore): sequences fetch/decode/execute/memory/
// writeback and drives datapath selects, write enables and ALUControl.
// Ports: clk, rst_n (sync, active-low), Opcode/Funct/Zero in; mux selects,
// enables, PCEn, ALUControl and the registered IllegalOp pulse out.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [2:0] ALUControl,
  output logic       IllegalOp
);

  state_t state_q, state_d;
  logic   illegal_op_q, illegal_op_d;

  aluop_t     alu_op;
  logic [2:0] alu_control;
  logic       funct_valid;

  // Raw per-state controls, before reset gating.
  logic       iord_c, mem_write_c, ir_write_c, reg_dst_c, mem_to_reg_c;
  logic       reg_write_c, alu_src_a_c, pc_write_c, branch_c;
  logic [1:0] alu_src_b_c, pc_src_c;

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct       (Funct),
    .alu_control (alu_control),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    illegal_op_d = 1'b0;
    alu_op       = ALUOP_ADD;
    iord_c       = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    pc_src_c     = 2'b00;
    pc_write_c   = 1'b0;
    branch_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write_c  = 1'b1;
        alu_src_b_c = 2'b01;
        pc_write_c  = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b_c = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d      = S_FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord_c  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a_c = 1'b1;
        alu_op      = ALUOP_FUNCT;
        if (funct_valid) begin
          state_d = S_ALUWB;
        end else begin
          // Unsupported funct: skip writeback entirely.
          state_d      = S_FETCH;
          illegal_op_d = 1'b1;
        end
      end
      S_ALUWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op      = ALUOP_CMP;
        pc_src_c    = 2'b01;
        branch_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src_c   = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every output to its idle value in the same cycle, so an
  // instruction abandoned by reset can never issue a partial write.
  assign IorD       = rst_n & iord_c;
  assign MemWrite   = rst_n & mem_write_c;
  assign IRWrite    = rst_n & ir_write_c;
  assign RegDst     = rst_n & reg_dst_c;
  assign MemtoReg   = rst_n & mem_to_reg_c;
  assign RegWrite   = rst_n & reg_write_c;
  assign ALUSrcA    = rst_n & alu_src_a_c;
  assign ALUSrcB    = rst_n ? alu_src_b_c : 2'b00;
  assign PCSrc      = rst_n ? pc_src_c : 2'b00;
  // Zero is same-cycle combinational from the ALU in BRANCH.
  assign PCEn       = rst_n & (pc_write_c | (branch_c & Zero));
  assign ALUControl = rst_n ? alu_control : ALU_ADD;
  assign IllegalOp  = rst_n & illegal_op_q;

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle MIPS control unit that sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath muxes, the write enables and the 3-bit `ALUControl` input of the ALU directly downstream. It consumes the ALU `Zero` flag for branch resolution. One instruction is in flight at a time; there is no pipelining.

## Interface
- No parameters; all encodings are fixed in `mips_pkg`.
- Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `Opcode` in 6: instruction bits [31:26], from the instruction register.
- `Funct` in 6: instruction bits [5:0].
- `Zero` in 1: ALU zero flag, combinational, same cycle.
- `IorD` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 1: register write address, 0 = rt, 1 = rd.
- `MemtoReg` out 1: register write data, 0 = ALUOut, 1 = Data.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A operand, 0 = PC, 1 = register A.
- `ALUSrcB` out 2: ALU B operand, 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `PCSrc` out 2: next-PC select, 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `PCEn` out 1: PC load, equal to `PCWrite | (Branch & Zero)`.
- `ALUControl` out 3: ALU operation code.
- `IllegalOp` out 1: registered one-cycle pulse on an unsupported opcode or funct.

## Operation
- Reset:
  - While `rst_n`=0 at a rising edge, state becomes FETCH and `IllegalOp` becomes 0.
  - While `rst_n`=0, every enable (`MemWrite`, `IRWrite`, `RegWrite`, `PCEn`) is forced to 0.
  - While `rst_n`=0, all mux selects are 0 and `ALUControl`=010.
  - Reset asserted mid-instruction abandons that instruction; no partial write occurs in the reset cycle.
- Moore FSM states and transitions:
  - FETCH: IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, PCWrite=1. Next state DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut). Next state by opcode:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 → EXECUTE.
    - 000100 (beq) → BRANCH.
    - 001000 (addi) → ADDIEX.
    - 000010 (j) → JUMP.
    - Any other opcode → FETCH, and set `IllegalOp` for the next cycle.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state MEMRD for lw, MEMWR for sw.
  - MEMRD: IorD=1. Next state MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
  - MEMWR: IorD=1, MemWrite=1. Next state FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, `ALUControl` from funct:
    - 100000 → 010.
    - 100010 → 110.
    - 100100 → 000.
    - 100101 → 001.
    - Any other funct → 010, and the next state is FETCH with `IllegalOp` pulsed (no writeback).
    - For a valid funct, next state ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=111 (the ALU's compare op; it updates `Zero`), PCSrc=01, Branch=1. Next state FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state FETCH.
  - JUMP: PCSrc=10, PCWrite=1. Next state FETCH.
- Any output not listed for a state is 0; `ALUControl` defaults to 010.
- `Opcode` and `Funct` are sampled from the IR, which is stable from DECODE until the next FETCH.

## Timing
- Cycles per instruction, counting FETCH:
  - lw: 5.
  - sw, R-type, addi: 4.
  - beq, j: 3.
  - Illegal opcode: 2. Illegal funct: 3.
- `PCEn` in BRANCH is combinational on `Zero` in the same cycle; the PC updates at the end of the BRANCH cycle.
- All other outputs are pure functions of state plus the registered `Funct`; no output depends on `Opcode` outside DECODE.
- `IllegalOp` is high for exactly the first cycle of the FETCH that follows the illegal decode.

## Structure
- `mips_pkg` holds:
  - The `state_t` enum (12 states).
  - Opcode constants: OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J.
  - Funct constants: F_ADD, F_SUB, F_AND, F_OR.
  - ALUControl constants: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_CMP=111.
- Sub-module `alu_decoder`: combinational; maps the FSM ALUOp request (ADD / CMP / FUNCT) plus `Funct` to `ALUControl` and a `funct_valid` flag.

## Test plan
- Reset: `rst_n`=0 for 2 cycles, then release → first cycle after release is FETCH with IRWrite=1, PCEn=1, ALUControl=010; during reset all enables are 0.
- lw (Opcode 100011) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 only in cycle 5 with MemtoReg=1; MemWrite never asserted.
- R-type sub (Funct 100010) → ALUControl=110 in EXECUTE, RegWrite=1 and RegDst=1 in cycle 4; Funct 101010 → IllegalOp pulse, no RegWrite, back to FETCH after 3 cycles.
- beq (000100) with Zero=1 in BRANCH → PCEn=1, PCSrc=01, ALUControl=111; same instruction with Zero=0 → PCEn=0.
- Opcode 111111 in DECODE → next cycle FETCH, IllegalOp=1 for exactly one cycle, no writes.
- sw with `rst_n` dropped during MEMADR → next cycle MemWrite=0, state FETCH; no memory write ever issued.
